fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameters SHALL be: AW, 32, address width; DW, 32, instruction width; RESET_PC, 32'h0000_0000, first fetch address.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  taken branch (brancher pc_sel qualified by branch opcode) or jump.
- redirect_pc  in  AW  redirect target.
- imem_req_valid  out  1  fetch request.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  AW  fetch address.
- imem_rsp_valid  in  1  response data present; one-cycle pulse.
- imem_rsp_data  in  DW  fetched word.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode consumes instruction.
- inst_data  out  DW  instruction word.
- inst_pc  out  AW  PC of inst_data.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low (rst_n).

Function
REQ-004 FSM states SHALL be REQ, WAIT, HOLD; at most one imem request SHALL be outstanding.
REQ-005 REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready -> WAIT.
REQ-006 WAIT: on imem_rsp_valid with squash=0, register inst_data<=imem_rsp_data, inst_pc<=pc, -> HOLD.
REQ-007 WAIT: on imem_rsp_valid with squash=1, discard data, clear squash, -> REQ.
REQ-008 HOLD: inst_valid=1, inst_data/inst_pc stable; on inst_ready, pc<=pc+4 (modulo 2^AW, wrap to 0), -> REQ.
REQ-009 Minimum latency: request accepted cycle N, response N+1, inst_valid N+2.
REQ-010 redirect_valid SHALL set pc<=redirect_pc with bits [1:0] forced to 0, in every state.
REQ-011 Redirect in REQ without imem_req_ready: stay REQ; imem_req_addr SHALL change to the new pc next cycle (only permitted address change while unaccepted).
REQ-012 Redirect in REQ with imem_req_ready same cycle: -> WAIT with squash=1.
REQ-013 Redirect in WAIT: squash<=1; if imem_rsp_valid same cycle, discard it and go to REQ directly.
REQ-014 Redirect in HOLD: drop held instruction, inst_valid=0 next cycle, -> REQ; redirect SHALL win over simultaneous inst_ready (no pc+4 applied).
REQ-015 inst_valid SHALL never be asserted for a squashed response.

Reset
REQ-016 While rst_n=0: state=REQ, pc=RESET_PC, squash=0, imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=RESET_PC.
REQ-017 First imem_req_valid SHALL assert in the first cycle after rst_n deasserts, address RESET_PC.
REQ-018 Reset mid-transaction SHALL abandon the outstanding request; a response arriving in the first post-reset cycle SHALL be ignored.

Structure
REQ-019 The state enum (fetch_state_e) and PC increment constant (4) SHALL live in the shared core package.
REQ-020 No sub-module; pc, squash, state and instruction registers are local.

Verification
REQ-021 Reset release, imem ready=1, rsp 1 cycle later -> addresses 0x0,0x4,0x8 issued; inst_pc 0x0,0x4,0x8 in order.
REQ-022 inst_ready=0 for 5 cycles in HOLD -> inst_data/inst_pc stable, no new imem request.
REQ-023 Redirect to 0x100 during WAIT for 0x8 -> 0x8 data never presented; next request 0x100; inst_pc=0x100.
REQ-024 Redirect to 0x203 with inst_ready in HOLD -> next request 0x200; inst_pc 0x200; no fetch of pc+4.
REQ-025 pc=0xFFFF_FFFC consumed -> next request 0x0000_0000.
REQ-026 rst_n low while in WAIT, response arrives cycle after release -> ignored; first inst_pc=RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared core definitions for the instruction fetch stage.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, a single-entry instruction
// holding register toward decode, and redirect handling with response squash.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned     AW       = 32,
  parameter int unsigned     DW       = 32,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [AW-1:0] imem_req_addr,
  input  logic          imem_rsp_valid,
  input  logic [DW-1:0] imem_rsp_data,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [DW-1:0] inst_data,
  output logic [AW-1:0] inst_pc
);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          squash_q, squash_d;
  logic [DW-1:0] inst_data_q, inst_data_d;
  logic [AW-1:0] inst_pc_q, inst_pc_d;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    squash_d    = squash_q;
    inst_data_d = inst_data_q;
    inst_pc_d   = inst_pc_q;

    case (state_q)
      ST_REQ: begin
        if (imem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          // A redirect arriving with the response kills it just like a stale squash.
          if (squash_q || redirect_valid) begin
            squash_d = 1'b0;
            state_d  = ST_REQ;
          end else begin
            inst_data_d = imem_rsp_data;
            inst_pc_d   = pc_q;
            state_d     = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (inst_ready) begin
          pc_d    = pc_q + AW'(PC_INC);
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase

    // Redirect overrides any sequential pc update; a request still in flight
    // after this cycle belongs to the old path and must be squashed.
    if (redirect_valid) begin
      pc_d = {redirect_pc[AW-1:2], 2'b00};
      if (state_q == ST_HOLD) state_d = ST_REQ;
      if (state_d == ST_WAIT) squash_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      squash_q    <= 1'b0;
      inst_data_q <= '0;
      inst_pc_q   <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      squash_q    <= squash_d;
      inst_data_q <= inst_data_d;
      inst_pc_q   <= inst_pc_d;
    end
  end

  assign imem_req_valid = rst_n && (state_q == ST_REQ);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == ST_HOLD);
  assign inst_data      = inst_data_q;
  assign inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed per-cycle vectors for fetch_stage: table for the main flow,
// hand-written sequences for squash, wrap and reset corner cases.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_stage #(.AW(32), .DW(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc)
  );

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        rspv;
    logic [31:0] rdat;
    logic        irdy;
    logic        ev;
    logic [31:0] ea;
    logic        eiv;
    logic [31:0] ed;
    logic [31:0] ep;
  } vec_t;

  function automatic vec_t mk(logic rv, logic [31:0] rpc, logic rdy, logic rspv,
                              logic [31:0] rdat, logic irdy, logic ev, logic [31:0] ea,
                              logic eiv, logic [31:0] ed, logic [31:0] ep);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.rspv = rspv; v.rdat = rdat; v.irdy = irdy;
    v.ev = ev; v.ea = ea; v.eiv = eiv; v.ed = ed; v.ep = ep;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance past the edge.
  task automatic step(input vec_t v, input string nm);
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    imem_req_ready = v.rdy;
    imem_rsp_valid = v.rspv;
    imem_rsp_data  = v.rdat;
    inst_ready     = v.irdy;
    #1;
    check({nm, " req_valid"}, 32'(imem_req_valid), 32'(v.ev));
    if (v.ev) check({nm, " req_addr"}, imem_req_addr, v.ea);
    check({nm, " inst_valid"}, 32'(inst_valid), 32'(v.eiv));
    if (v.eiv) begin
      check({nm, " inst_data"}, inst_data, v.ed);
      check({nm, " inst_pc"}, inst_pc, v.ep);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b0;
    @(posedge clk); #1;
    check({nm, " rst req_valid"}, 32'(imem_req_valid), 32'd0);
    check({nm, " rst inst_valid"}, 32'(inst_valid), 32'd0);
    check({nm, " rst inst_data"}, inst_data, 32'd0);
    check({nm, " rst inst_pc"}, inst_pc, 32'd0);
    rst_n = 1'b1;
  endtask

  // Request accepted, response next cycle, consumed in HOLD.
  task automatic fetch_one(input logic [31:0] a, input logic [31:0] d, input string nm);
    step(mk(0, 0, 1, 0, 0, 0, 1, a, 0, 0, 0), {nm, " req"});
    step(mk(0, 0, 0, 1, d, 0, 0, 0, 0, 0, 0), {nm, " rsp"});
    step(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, d, a), {nm, " hold"});
  endtask

  vec_t tbl[27];

  initial begin
    //            rv rpc           rdy rspv rdat          irdy ev ea           eiv ed            ep
    tbl[0]  = mk(0, 0,            0,  0,   0,            0,   1, 32'h0,       0, 0,            0);
    tbl[1]  = mk(0, 0,            1,  0,   0,            0,   1, 32'h0,       0, 0,            0);
    tbl[2]  = mk(0, 0,            0,  1,   32'hA000_0000,0,   0, 0,           0, 0,            0);
    tbl[3]  = mk(0, 0,            0,  0,   0,            1,   0, 0,           1, 32'hA000_0000,32'h0);
    tbl[4]  = mk(0, 0,            1,  0,   0,            0,   1, 32'h4,       0, 0,            0);
    tbl[5]  = mk(0, 0,            0,  1,   32'hA000_0004,0,   0, 0,           0, 0,            0);
    for (int i = 6; i <= 10; i++)
      tbl[i] = mk(0, 0,           0,  0,   0,            0,   0, 0,           1, 32'hA000_0004,32'h4);
    tbl[11] = mk(0, 0,            0,  0,   0,            1,   0, 0,           1, 32'hA000_0004,32'h4);
    tbl[12] = mk(0, 0,            1,  0,   0,            0,   1, 32'h8,       0, 0,            0);
    tbl[13] = mk(0, 0,            0,  1,   32'hA000_0008,0,   0, 0,           0, 0,            0);
    tbl[14] = mk(0, 0,            0,  0,   0,            1,   0, 0,           1, 32'hA000_0008,32'h8);
    // redirect while REQ unaccepted, then redirect with acceptance
    tbl[15] = mk(1, 32'h40,       0,  0,   0,            0,   1, 32'hC,       0, 0,            0);
    tbl[16] = mk(0, 0,            0,  0,   0,            0,   1, 32'h40,      0, 0,            0);
    tbl[17] = mk(1, 32'h80,       1,  0,   0,            0,   1, 32'h40,      0, 0,            0);
    tbl[18] = mk(0, 0,            0,  1,   32'hBAD0_0040,0,   0, 0,           0, 0,            0);
    tbl[19] = mk(0, 0,            1,  0,   0,            0,   1, 32'h80,      0, 0,            0);
    tbl[20] = mk(0, 0,            0,  1,   32'hB000_0080,0,   0, 0,           0, 0,            0);
    tbl[21] = mk(0, 0,            0,  0,   0,            1,   0, 0,           1, 32'hB000_0080,32'h80);
    // redirect in WAIT coincident with the response
    tbl[22] = mk(0, 0,            1,  0,   0,            0,   1, 32'h84,      0, 0,            0);
    tbl[23] = mk(1, 32'h300,      0,  1,   32'hDEAD_0084,0,   0, 0,           0, 0,            0);
    tbl[24] = mk(0, 0,            1,  0,   0,            0,   1, 32'h300,     0, 0,            0);
    tbl[25] = mk(0, 0,            0,  1,   32'hC000_0300,0,   0, 0,           0, 0,            0);
    tbl[26] = mk(0, 0,            0,  0,   0,            1,   0, 0,           1, 32'hC000_0300,32'h300);

    do_reset("init");
    for (int i = 0; i < 27; i++) step(tbl[i], $sformatf("row%0d", i));

    // Redirect to 0x100 while waiting on 0x8: late 0x8 data must be dropped.
    do_reset("redir_wait");
    fetch_one(32'h0, 32'h1111_0000, "rw0");
    fetch_one(32'h4, 32'h1111_0004, "rw4");
    step(mk(0, 0,        1, 0, 0,             0, 1, 32'h8, 0, 0, 0), "rw req8");
    step(mk(1, 32'h100,  0, 0, 0,             0, 0, 0,     0, 0, 0), "rw redirect");
    step(mk(0, 0,        0, 1, 32'h1111_0008, 0, 0, 0,     0, 0, 0), "rw stale rsp");
    fetch_one(32'h100, 32'h2222_0100, "rw100");

    // Redirect to 0x203 with simultaneous inst_ready in HOLD: redirect wins.
    step(mk(0, 0,        1, 0, 0,             0, 1, 32'h104, 0, 0, 0), "rh req104");
    step(mk(0, 0,        0, 1, 32'h3333_0104, 0, 0, 0,       0, 0, 0), "rh rsp104");
    step(mk(1, 32'h203,  0, 0, 0,             1, 0, 0,       1, 32'h3333_0104, 32'h104), "rh redirect");
    step(mk(0, 0,        0, 0, 0,             0, 1, 32'h200, 0, 0, 0), "rh next");
    fetch_one(32'h200, 32'h4444_0200, "rh200");

    // PC wrap at the top of the address space.
    step(mk(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 1, 32'h204, 0, 0, 0), "wrap redirect");
    fetch_one(32'hFFFF_FFFC, 32'h5555_FFFC, "wrapF");
    step(mk(0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0), "wrap next");

    // Reset while in WAIT; a response in the first post-reset cycle is ignored.
    do_reset("rst_wait_pre");
    step(mk(0, 0, 1, 0, 0, 0, 1, 32'h0, 0, 0, 0), "rwt req0");
    do_reset("rst_wait");
    step(mk(0, 0, 0, 1, 32'hBAD0_BAD0, 0, 1, 32'h0, 0, 0, 0), "rwt late rsp");
    step(mk(0, 0, 0, 0, 0,             0, 1, 32'h0, 0, 0, 0), "rwt still req");
    fetch_one(32'h0, 32'h6666_0000, "rwt0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
